// File: rtl/irq_pwm_sequencer_if.sv
// AXI4-Lite bus bundle used by irq_pwm_sequencer.
// master modport: address/data/valid outputs and ready/response inputs for the
// sequencer. slave modport: the opposite directions, for a register-slave model.
interface irq_pwm_sequencer_if #(
  parameter int ADDR_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [31:0]           m_axi_wdata;
  logic [3:0]            m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [31:0]           m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/irq_pwm_sequencer.sv
// irq_pwm_sequencer: CPU-less AXI4-Lite master. After reset it enables the
// interrupt controller (GIE, IER), then for every irq reads ISR, acknowledges
// the read value through IAR and steps the PWM duty register.
// Ports:
//   axi_aclk, axi_aresetn : clock, asynchronous active-low reset
//   en                    : sequencer enable (honoured in IDLE / WAIT_IRQ)
//   irq                   : level interrupt from the controller
//   m_axi                 : AXI4-Lite master bus (interface, master modport)
//   duty                  : last duty value written to the PWM
//   svc_count, spur_count : serviced / spurious interrupt statistics
//   err_resp, err_timeout : sticky bus-error and phase-timeout flags
//   busy                  : high outside IDLE and WAIT_IRQ
module irq_pwm_sequencer #(
  parameter int                    ADDR_WIDTH = 7,
  parameter logic [ADDR_WIDTH-1:0] INTR_BASE  = 7'h40,
  parameter logic [ADDR_WIDTH-1:0] PWM_BASE   = 7'h00,
  parameter logic [31:0]           IER_MASK   = 32'h1,
  parameter logic [7:0]            DUTY_INIT  = 8'h00,
  parameter logic [7:0]            DUTY_STEP  = 8'h10,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic                       en,
  input  logic                       irq,
  irq_pwm_sequencer_if.master        m_axi,
  output logic [7:0]                 duty,
  output logic [15:0]                svc_count,
  output logic [7:0]                 spur_count,
  output logic                       err_resp,
  output logic                       err_timeout,
  output logic                       busy
);

  localparam logic [ADDR_WIDTH-1:0] GIE_ADDR = INTR_BASE;
  localparam logic [ADDR_WIDTH-1:0] IER_ADDR = INTR_BASE + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ISR_ADDR = INTR_BASE + ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] IAR_ADDR = INTR_BASE + ADDR_WIDTH'(12);
  localparam int                    CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]         TMAX     = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, INIT_GIE, INIT_IER, WAIT_IRQ, RD_ISR, WR_IAR, WR_PWM
  } state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic          in_write;
  logic          b_done;
  logic          r_done;

  assign busy     = !(state inside {IDLE, WAIT_IRQ});
  assign in_write = state inside {INIT_GIE, INIT_IER, WR_IAR, WR_PWM};
  assign b_done   = m_axi.m_axi_bvalid && m_axi.m_axi_bready;
  assign r_done   = m_axi.m_axi_rvalid && m_axi.m_axi_rready;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state               <= IDLE;
      tcnt                <= '0;
      m_axi.m_axi_awaddr  <= '0;
      m_axi.m_axi_awvalid <= 1'b0;
      m_axi.m_axi_wdata   <= '0;
      m_axi.m_axi_wstrb   <= '0;
      m_axi.m_axi_wvalid  <= 1'b0;
      m_axi.m_axi_bready  <= 1'b0;
      m_axi.m_axi_araddr  <= '0;
      m_axi.m_axi_arvalid <= 1'b0;
      m_axi.m_axi_rready  <= 1'b0;
      duty                <= DUTY_INIT;
      svc_count           <= '0;
      spur_count          <= '0;
      err_resp            <= 1'b0;
      err_timeout         <= 1'b0;
    end else begin
      // Phase watchdog: counts only while a bus phase is outstanding; every
      // state transition below reloads it to zero.
      if (busy) begin
        if (tcnt != TMAX) tcnt <= tcnt + CW'(1);
        if (tcnt == TMAX - CW'(1)) err_timeout <= 1'b1;
      end

      // AW and W handshakes retire independently; B may arrive at any time.
      if (in_write) begin
        if (m_axi.m_axi_awvalid && m_axi.m_axi_awready) m_axi.m_axi_awvalid <= 1'b0;
        if (m_axi.m_axi_wvalid && m_axi.m_axi_wready)   m_axi.m_axi_wvalid  <= 1'b0;
        if (b_done && m_axi.m_axi_bresp != 2'b00)        err_resp            <= 1'b1;
      end

      // Assignments below launch the next phase and override the handshake
      // clears above in the same cycle.
      case (state)
        IDLE: begin
          if (en) begin
            state               <= INIT_GIE;
            tcnt                <= '0;
            m_axi.m_axi_awaddr  <= GIE_ADDR;
            m_axi.m_axi_wdata   <= 32'h1;
            m_axi.m_axi_wstrb   <= 4'hF;
            m_axi.m_axi_awvalid <= 1'b1;
            m_axi.m_axi_wvalid  <= 1'b1;
            m_axi.m_axi_bready  <= 1'b1;
          end
        end
        INIT_GIE: begin
          if (b_done) begin
            state               <= INIT_IER;
            tcnt                <= '0;
            m_axi.m_axi_awaddr  <= IER_ADDR;
            m_axi.m_axi_wdata   <= IER_MASK;
            m_axi.m_axi_awvalid <= 1'b1;
            m_axi.m_axi_wvalid  <= 1'b1;
            m_axi.m_axi_bready  <= 1'b1;
          end
        end
        INIT_IER, WR_PWM: begin
          if (b_done) begin
            state               <= WAIT_IRQ;
            tcnt                <= '0;
            m_axi.m_axi_awvalid <= 1'b0;
            m_axi.m_axi_wvalid  <= 1'b0;
            m_axi.m_axi_bready  <= 1'b0;
            m_axi.m_axi_wstrb   <= '0;
            if (state == WR_PWM) begin
              duty      <= duty + DUTY_STEP;
              svc_count <= svc_count + 16'd1;
            end
          end
        end
        WAIT_IRQ: begin
          if (!en) begin
            state <= IDLE;
          end else if (irq) begin
            state               <= RD_ISR;
            tcnt                <= '0;
            m_axi.m_axi_araddr  <= ISR_ADDR;
            m_axi.m_axi_arvalid <= 1'b1;
            m_axi.m_axi_rready  <= 1'b1;
          end
        end
        RD_ISR: begin
          if (m_axi.m_axi_arvalid && m_axi.m_axi_arready) m_axi.m_axi_arvalid <= 1'b0;
          if (r_done) begin
            tcnt                <= '0;
            m_axi.m_axi_arvalid <= 1'b0;
            m_axi.m_axi_rready  <= 1'b0;
            if (m_axi.m_axi_rresp != 2'b00) err_resp <= 1'b1;
            if (m_axi.m_axi_rdata == 32'h0 && spur_count != 8'hFF)
              spur_count <= spur_count + 8'd1;
            if (m_axi.m_axi_rresp != 2'b00 || m_axi.m_axi_rdata == 32'h0) begin
              state <= WAIT_IRQ;
            end else begin
              state               <= WR_IAR;
              m_axi.m_axi_awaddr  <= IAR_ADDR;
              m_axi.m_axi_wdata   <= m_axi.m_axi_rdata;
              m_axi.m_axi_wstrb   <= 4'hF;
              m_axi.m_axi_awvalid <= 1'b1;
              m_axi.m_axi_wvalid  <= 1'b1;
              m_axi.m_axi_bready  <= 1'b1;
            end
          end
        end
        WR_IAR: begin
          if (b_done) begin
            state               <= WR_PWM;
            tcnt                <= '0;
            m_axi.m_axi_awaddr  <= PWM_BASE;
            m_axi.m_axi_wdata   <= {24'h0, duty + DUTY_STEP};
            m_axi.m_axi_awvalid <= 1'b1;
            m_axi.m_axi_wvalid  <= 1'b1;
            m_axi.m_axi_bready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pwm_sequencer.sv
module tb_irq_pwm_sequencer;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        irq = 1'b0;
  logic [7:0]  duty;
  logic [15:0] svc_count;
  logic [7:0]  spur_count;
  logic        err_resp, err_timeout, busy;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // Slave knobs
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0;
  logic [31:0] rdata_val = 32'h1;
  logic [1:0]  rresp_val = 2'b00, bresp_val = 2'b00;

  // Slave state and transaction logs
  bit          aw_done, w_done, ar_done;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt;
  logic [6:0]  cur_aw, cur_ar;
  logic [31:0] cur_w;
  int          cur_awc, cur_wc;
  logic [6:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          awc_q[$], wc_q[$];
  logic [6:0]  ra_q[$];
  int          n;

  irq_pwm_sequencer_if #(.ADDR_WIDTH(7)) m_axi ();

  irq_pwm_sequencer #(
    .ADDR_WIDTH(7), .INTR_BASE(7'h40), .PWM_BASE(7'h00), .IER_MASK(32'h1),
    .DUTY_INIT(8'h00), .DUTY_STEP(8'h10), .TIMEOUT(255)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rstn), .en(en), .irq(irq), .m_axi(m_axi),
    .duty(duty), .svc_count(svc_count), .spur_count(spur_count),
    .err_resp(err_resp), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic slave_reset();
    m_axi.m_axi_awready = 1'b0; m_axi.m_axi_wready = 1'b0;
    m_axi.m_axi_bvalid  = 1'b0; m_axi.m_axi_bresp  = 2'b00;
    m_axi.m_axi_arready = 1'b0; m_axi.m_axi_rvalid = 1'b0;
    m_axi.m_axi_rdata   = '0;   m_axi.m_axi_rresp  = 2'b00;
    aw_done = 0; w_done = 0; ar_done = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0;
  endtask

  // Register-slave model: reacts on the falling edge, so a ready/valid raised
  // here is seen by the DUT on the next rising edge.
  always @(negedge clk) begin
    if (m_axi.m_axi_bvalid) begin
      m_axi.m_axi_bvalid = 1'b0;
      aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (m_axi.m_axi_awready) begin
        m_axi.m_axi_awready = 1'b0; aw_done = 1; cur_awc = cyc;
      end else if (m_axi.m_axi_awvalid && !aw_done) begin
        if (aw_cnt >= aw_delay) begin m_axi.m_axi_awready = 1'b1; cur_aw = m_axi.m_axi_awaddr; end
        else aw_cnt++;
      end
      if (m_axi.m_axi_wready) begin
        m_axi.m_axi_wready = 1'b0; w_done = 1; cur_wc = cyc;
      end else if (m_axi.m_axi_wvalid && !w_done) begin
        if (w_cnt >= w_delay) begin m_axi.m_axi_wready = 1'b1; cur_w = m_axi.m_axi_wdata; end
        else w_cnt++;
      end
      if (aw_done && w_done) begin
        if (b_cnt >= b_delay) begin
          m_axi.m_axi_bvalid = 1'b1; m_axi.m_axi_bresp = bresp_val;
          wa_q.push_back(cur_aw); wd_q.push_back(cur_w);
          awc_q.push_back(cur_awc); wc_q.push_back(cur_wc);
        end else b_cnt++;
      end
    end
    if (m_axi.m_axi_rvalid) begin
      m_axi.m_axi_rvalid = 1'b0;
    end else begin
      if (m_axi.m_axi_arready) begin
        m_axi.m_axi_arready = 1'b0; ar_done = 1;
      end else if (m_axi.m_axi_arvalid && !ar_done) begin
        if (ar_cnt >= ar_delay) begin m_axi.m_axi_arready = 1'b1; cur_ar = m_axi.m_axi_araddr; end
        else ar_cnt++;
      end
      if (ar_done) begin
        m_axi.m_axi_rvalid = 1'b1; m_axi.m_axi_rdata = rdata_val;
        m_axi.m_axi_rresp = rresp_val; ar_done = 0; ar_cnt = 0;
        ra_q.push_back(cur_ar);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy; i++) tick();
    chk(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic kick(input string tag);
    irq = 1'b1;
    for (int i = 0; i < 20 && !m_axi.m_axi_arvalid; i++) tick();
    chk(tag, {31'h0, m_axi.m_axi_arvalid}, 32'h1);
    irq = 1'b0;
  endtask

  task automatic service(input string tag);
    kick(tag);
    tick();
    wait_idle(tag);
  endtask

  initial begin
    slave_reset();
    en = 1'b1;
    #12;
    chk("rst_awvalid", {31'h0, m_axi.m_axi_awvalid}, 32'h0);
    chk("rst_arvalid", {31'h0, m_axi.m_axi_arvalid}, 32'h0);
    chk("rst_duty", {24'h0, duty}, 32'h00);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    // Initialisation writes
    @(negedge clk); rstn = 1'b1;
    tick(); tick();
    wait_idle("init_idle");
    chk("init_wcount", wa_q.size(), 32'd2);
    chk("gie_addr", {25'h0, wa_q[0]}, 32'h40);
    chk("gie_data", wd_q[0], 32'h1);
    chk("ier_addr", {25'h0, wa_q[1]}, 32'h44);
    chk("ier_data", wd_q[1], 32'h1);
    chk("init_duty", {24'h0, duty}, 32'h00);

    // First interrupt, minimum latency irq -> arvalid
    irq = 1'b1;
    tick();
    chk("irq_latency", {31'h0, m_axi.m_axi_arvalid}, 32'h1);
    irq = 1'b0;
    tick();
    wait_idle("svc1_idle");
    chk("isr_addr", {25'h0, ra_q[0]}, 32'h48);
    chk("iar_addr", {25'h0, wa_q[2]}, 32'h4C);
    chk("iar_data", wd_q[2], 32'h1);
    chk("pwm_addr", {25'h0, wa_q[3]}, 32'h00);
    chk("pwm_data", wd_q[3], 32'h10);
    chk("svc1_duty", {24'h0, duty}, 32'h10);
    chk("svc1_count", {16'h0, svc_count}, 32'd1);

    // 15 more services: duty wraps to zero
    for (int k = 0; k < 15; k++) service("svc_loop");
    chk("wrap_count", {16'h0, svc_count}, 32'd16);
    chk("wrap_duty", {24'h0, duty}, 32'h00);
    chk("wrap_pwm_data", wd_q[wd_q.size()-1], 32'h00);
    chk("wrap_pwm_addr", {25'h0, wa_q[wa_q.size()-1]}, 32'h00);

    // Slow slave: awready 3 cycles after wready, bvalid 2 cycles later
    aw_delay = 3; b_delay = 2;
    n = wa_q.size();
    service("slow_svc");
    chk("slow_aw_after_w", awc_q[n] - wc_q[n], 32'd3);
    chk("slow_iar_addr", {25'h0, wa_q[n]}, 32'h4C);
    chk("slow_duty", {24'h0, duty}, 32'h10);
    chk("slow_count", {16'h0, svc_count}, 32'd17);
    chk("slow_err_resp", {31'h0, err_resp}, 32'h0);
    chk("slow_err_to", {31'h0, err_timeout}, 32'h0);
    aw_delay = 0; b_delay = 0;

    // Spurious: ISR reads zero
    rdata_val = 32'h0;
    n = wa_q.size();
    service("spur_svc");
    chk("spur_nowrite", wa_q.size(), n);
    chk("spur_count", {24'h0, spur_count}, 32'd1);
    chk("spur_svc_count", {16'h0, svc_count}, 32'd17);

    // ISR read with SLVERR
    rdata_val = 32'h5; rresp_val = 2'b10;
    service("slverr_svc");
    chk("slverr_err", {31'h0, err_resp}, 32'h1);
    chk("slverr_nowrite", wa_q.size(), n);
    chk("slverr_spur", {24'h0, spur_count}, 32'd1);
    rdata_val = 32'h1; rresp_val = 2'b00;

    // awready withheld: timeout flag, valid held
    aw_delay = 1000;
    kick("to_kick");
    for (int i = 0; i < 50 && !m_axi.m_axi_awvalid; i++) tick();
    chk("to_awvalid_start", {31'h0, m_axi.m_axi_awvalid}, 32'h1);
    repeat (250) tick();
    chk("to_before", {31'h0, err_timeout}, 32'h0);
    repeat (10) tick();
    chk("to_after", {31'h0, err_timeout}, 32'h1);
    chk("to_awvalid_held", {31'h0, m_axi.m_axi_awvalid}, 32'h1);

    // Reset mid-write
    #2;
    rstn = 1'b0;
    slave_reset();
    #1;
    chk("mr_awvalid", {31'h0, m_axi.m_axi_awvalid}, 32'h0);
    chk("mr_wvalid", {31'h0, m_axi.m_axi_wvalid}, 32'h0);
    chk("mr_bready", {31'h0, m_axi.m_axi_bready}, 32'h0);
    chk("mr_awaddr", {25'h0, m_axi.m_axi_awaddr}, 32'h0);
    chk("mr_wdata", m_axi.m_axi_wdata, 32'h0);
    chk("mr_wstrb", {28'h0, m_axi.m_axi_wstrb}, 32'h0);
    chk("mr_duty", {24'h0, duty}, 32'h00);
    chk("mr_svc", {16'h0, svc_count}, 32'h0);
    chk("mr_spur", {24'h0, spur_count}, 32'h0);
    chk("mr_err_resp", {31'h0, err_resp}, 32'h0);
    chk("mr_err_to", {31'h0, err_timeout}, 32'h0);
    chk("mr_busy", {31'h0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
